fp_div_ctrl: RTL and testbench

Issue and retire controller for the single-precision divider. It accepts one divide request at a time over a valid/ready handshake and registers the operands. It holds the divider inputs stable for the divider's fixed latency, then captures the result and exception outputs. It presents the result downstream over valid/ready and accumulates sticky exception flags (fflags) for the FPU status register.

---
 rtl/fp_div_ctrl_pkg.sv | 22 ++
 rtl/fp_div_ctrl_fflags_acc.sv | 15 +
 rtl/fp_div_ctrl.sv | 94 +++++++++
 tb/tb_fp_div_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fp_div_ctrl_pkg.sv
// fp_div_ctrl_pkg: shared FPU divider-control types, rounding modes, flag indices
package fp_div_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
   localparam logic [2:0] RNE = 3'b000;
   localparam logic [2:0] RZ = 3'b001;
   localparam logic [2:0] RD = 3'b010;
   localparam logic [2:0] RU = 3'b011;
   localparam logic [2:0] RNA = 3'b100;
   localparam logic [2:0] DYN = 3'b111;
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam int INV = 4;
   localparam int DZ = 3;
   localparam int OV = 2;
   localparam int UN = 1;
   localparam int NX = 0;
   function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
      return rm == DYN ? frm : rm;
   endfunction
   function automatic logic rm_legal(input logic [2:0] rm);
      return rm inside {RNE, RZ, RD, RU, RNA};
   endfunction
endpackage

// File: rtl/fp_div_ctrl_fflags_acc.sv
// fflags_acc: sticky exception-flag register; a clear in the same clock as a set keeps only the new flags
module fflags_acc #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         set,
   input  logic         clr,
   input  logic [N-1:0] flags,
   output logic [N-1:0] fflags
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) fflags <= '0;
      else if (set || clr) fflags <= (clr ? '0 : fflags) | (set ? flags : '0);
endmodule

// File: rtl/fp_div_ctrl.sv
// fp_div_ctrl: issues one divide at a time to a fixed-latency divider and retires result plus sticky flags
module fp_div_ctrl
   import fp_div_ctrl_pkg::*;
#(
   parameter int W = 32,
   parameter int LAT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   input  logic [2:0]   req_rm,
   input  logic [2:0]   frm,
   output logic [W-1:0] div_in1,
   output logic [W-1:0] div_in2,
   output logic [2:0]   div_round_m,
   output logic         div_act,
   input  logic [W-1:0] div_out,
   input  logic         div_ov,
   input  logic         div_un,
   input  logic         div_inv,
   input  logic         div_dz,
   input  logic         div_nx,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic [4:0]   rsp_flags,
   output logic [4:0]   fflags,
   input  logic         fflags_clr,
   output logic         busy
);
   localparam int CW = $clog2(LAT);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0] rm_res;
   logic legal, accept, done, capture;
   logic [4:0] new_flags;
   always_comb begin
      rm_res = resolve_rm(req_rm, frm);
      legal = rm_legal(rm_res);
      req_ready = rst && state == IDLE;
      accept = req_valid && req_ready;
      done = state == WAIT && cnt == '0;
      capture = done || (accept && !legal);
      new_flags = '0;
      new_flags[INV] = done ? div_inv : 1'b1;
      new_flags[DZ] = done && div_dz;
      new_flags[OV] = done && div_ov;
      new_flags[UN] = done && div_un;
      new_flags[NX] = done && div_nx;
      div_act = state == WAIT;
      rsp_valid = state == HOLD;
      busy = state != IDLE;
      state_n = state;
      case (state)
         IDLE: state_n = accept ? (legal ? WAIT : HOLD) : IDLE;
         WAIT: state_n = done ? HOLD : WAIT;
         HOLD: state_n = rsp_ready ? IDLE : HOLD;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         div_in1 <= '0;
         div_in2 <= '0;
         div_round_m <= '0;
         rsp_result <= '0;
         rsp_flags <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            div_in1 <= req_a;
            div_in2 <= req_b;
            div_round_m <= rm_res;
            cnt <= CW'(LAT - 1);
         end else if (state == WAIT) cnt <= cnt - CW'(1);
         if (capture) begin
            rsp_result <= done ? div_out : W'(CANON_NAN);
            rsp_flags <= new_flags;
         end
      end
   fflags_acc #(.N(5)) u_acc (
      .clk(clk),
      .rst(rst),
      .set(capture),
      .clr(fflags_clr),
      .flags(new_flags),
      .fflags(fflags)
   );
endmodule

// File: tb/tb_fp_div_ctrl.sv
// tb_fp_div_ctrl: directed and randomized checks of fp_div_ctrl; the bench plays the fixed-latency divider
module tb_fp_div_ctrl;
   localparam int W = 32;
   localparam int LAT = 4;
   logic clk = 1'b0, rst = 1'b0;
   logic req_valid = 1'b0, rsp_ready = 1'b0, fflags_clr = 1'b0;
   logic [W-1:0] req_a = '0, req_b = '0, div_out = '0;
   logic [2:0] req_rm = '0, frm = '0;
   logic div_ov = 1'b0, div_un = 1'b0, div_inv = 1'b0, div_dz = 1'b0, div_nx = 1'b0;
   logic req_ready, div_act, rsp_valid, busy;
   logic [W-1:0] div_in1, div_in2, rsp_result;
   logic [2:0] div_round_m;
   logic [4:0] rsp_flags, fflags;
   logic [4:0] exp_ff = '0;
   int checks = 0, errors = 0;

   fp_div_ctrl #(.W(W), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .frm(frm),
      .div_in1(div_in1), .div_in2(div_in2), .div_round_m(div_round_m), .div_act(div_act),
      .div_out(div_out), .div_ov(div_ov), .div_un(div_un), .div_inv(div_inv),
      .div_dz(div_dz), .div_nx(div_nx), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .fflags(fflags),
      .fflags_clr(fflags_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_result"}, rsp_result, 32'd0);
      chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
      chk({tag, "_fflags"}, 32'(fflags), 32'd0);
      chk({tag, "_div_in1"}, div_in1, 32'd0);
      chk({tag, "_div_in2"}, div_in2, 32'd0);
      chk({tag, "_div_round_m"}, 32'(div_round_m), 32'd0);
      chk({tag, "_div_act"}, 32'(div_act), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // One full operation: request, divider stand-in, capture, optional HOLD stall, retire.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [2:0] fv, input logic [31:0] res, input logic [4:0] flg,
                        input int hold, input bit clr);
      logic [2:0] rmr;
      logic legal;
      logic [31:0] er;
      logic [4:0] ef;
      rmr = (rm == 3'b111) ? fv : rm;
      legal = rmr <= 3'd4;
      er = legal ? res : 32'h7FC0_0000;
      ef = legal ? flg : 5'b10000;
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_a = a;
      req_b = b;
      req_rm = rm;
      frm = fv;
      tick;
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
      req_rm = 3'($urandom);
      frm = 3'($urandom);
      if (legal) begin
         for (int k = 1; k <= LAT; k++) begin
            chk("wait_div_act", 32'(div_act), 32'd1);
            chk("wait_div_in1", div_in1, a);
            chk("wait_div_in2", div_in2, b);
            chk("wait_round_m", 32'(rmr), 32'(div_round_m));
            chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("wait_req_ready", 32'(req_ready), 32'd0);
            div_out = (k == LAT) ? res : $urandom;
            {div_inv, div_dz, div_ov, div_un, div_nx} = (k == LAT) ? flg : 5'($urandom);
            fflags_clr = (k == LAT) && clr;
            tick;
         end
         fflags_clr = 1'b0;
         div_out = $urandom;
         {div_inv, div_dz, div_ov, div_un, div_nx} = 5'($urandom);
      end else chk("illegal_div_act", 32'(div_act), 32'd0);
      exp_ff = (clr && legal) ? ef : (exp_ff | ef);
      chk("cap_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("cap_rsp_result", rsp_result, er);
      chk("cap_rsp_flags", 32'(rsp_flags), 32'(ef));
      chk("cap_fflags", 32'(fflags), 32'(exp_ff));
      chk("cap_busy", 32'(busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
         req_valid = (i == 0);
         tick;
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_result", rsp_result, er);
         chk("hold_rsp_flags", 32'(rsp_flags), 32'(ef));
         chk("hold_fflags", 32'(fflags), 32'(exp_ff));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_div_act", 32'(div_act), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("ret_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("ret_req_ready", 32'(req_ready), 32'd1);
      chk("ret_busy", 32'(busy), 32'd0);
      chk("ret_fflags", 32'(fflags), 32'(exp_ff));
   endtask

   initial begin
      #2;
      chk_all_zero("reset");
      tick;
      tick;
      chk_all_zero("reset_clocked");
      rst = 1'b1;
      #1;
      chk("post_reset_ready", 32'(req_ready), 32'd1);
      tick;
      do_op(32'h40C0_0000, 32'h4000_0000, 3'b000, 3'b000, 32'h4040_0000, 5'b00000, 0, 1'b0);
      do_op(32'h3F80_0000, 32'h4040_0000, 3'b111, 3'b000, 32'h3EAA_AAAB, 5'b00001, 0, 1'b0);
      do_op(32'h3F80_0000, 32'h4040_0000, 3'b111, 3'b001, 32'h3EAA_AAAA, 5'b00001, 1, 1'b0);
      fflags_clr = 1'b1;
      tick;
      fflags_clr = 1'b0;
      exp_ff = '0;
      chk("clear_alone", 32'(fflags), 32'd0);
      do_op(32'h3F80_0000, 32'h0000_0000, 3'b000, 3'b000, 32'h7F80_0000, 5'b01000, 0, 1'b0);
      do_op(32'h40C0_0000, 32'h4000_0000, 3'b000, 3'b000, 32'h4040_0000, 5'b00000, 0, 1'b0);
      chk("dz_sticky", 32'(fflags), 32'b01000);
      do_op(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 3'b000, 32'h0, 5'b0, 0, 1'b0);
      do_op(32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 3'b110, 32'h0, 5'b0, 2, 1'b0);
      do_op(32'h40C0_0000, 32'h4000_0000, 3'b011, 3'b000, 32'h4040_0000, 5'b00100, 5, 1'b0);
      do_op(32'h3F80_0000, 32'h4040_0000, 3'b000, 3'b000, 32'h3EAA_AAAB, 5'b00001, 0, 1'b1);
      chk("clear_with_capture", 32'(fflags), 32'b00001);
      req_valid = 1'b1;
      req_a = 32'h40C0_0000;
      req_b = 32'h4000_0000;
      req_rm = 3'b000;
      tick;
      req_valid = 1'b0;
      for (int k = 1; k < LAT; k++) begin
         div_out = 32'hDEAD_BEEF;
         {div_inv, div_dz, div_ov, div_un, div_nx} = 5'b11111;
         tick;
      end
      rst = 1'b0;
      #1;
      exp_ff = '0;
      chk_all_zero("mid_op_reset");
      tick;
      tick;
      chk_all_zero("mid_op_reset_held");
      rst = 1'b1;
      #1;
      do_op(32'h40C0_0000, 32'h4000_0000, 3'b000, 3'b000, 32'h4040_0000, 5'b00000, 0, 1'b0);
      for (int n = 0; n < 30; n++)
         do_op($urandom, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               $urandom, 5'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
